// File: rtl/router_pkg.sv
// router_pkg
// Shared definitions for the router packet source:
//   - field widths of the router packet format (address, length, data)
//   - payload buffer geometry (one slot per possible payload byte)
//   - FSM state encoding
//   - header byte builder
package router_pkg;

  localparam int ADDR_W      = 2;
  localparam int LEN_W       = 6;
  localparam int DATA_W      = 8;
  localparam int MAX_PAYLOAD = 63;
  localparam int BUF_DEPTH   = MAX_PAYLOAD + 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FILL    = 3'd1,
    ST_HEADER  = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_PARITY  = 3'd4,
    ST_GAP     = 3'd5
  } state_e;

  // Router header layout: length in the upper bits, destination in the lower bits.
  function automatic logic [DATA_W-1:0] hdr_byte(input logic [LEN_W-1:0]  len,
                                                 input logic [ADDR_W-1:0] addr);
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_pkt_gen_if.sv
// router_pkt_gen_if
// Groups the host request/payload handshakes, the router-facing pins and the
// status counters of router_pkt_gen.
//   master : the packet generator (drives req_ready, pay_ready, pkt_valid,
//            data_out, pkt_cnt, drop_cnt)
//   slave  : the surrounding host/router environment
// Optional: ROUTER_PKT_GEN_PERR_INJ_EN adds perr_inj (host -> generator).
interface router_pkt_gen_if;
  import router_pkg::*;

  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              req_ready;

  logic              pay_valid;
  logic [DATA_W-1:0] pay_data;
  logic              pay_ready;

  logic              busy;
  logic              pkt_valid;
  logic [DATA_W-1:0] data_out;

  logic [15:0]       pkt_cnt;
  logic [7:0]        drop_cnt;

`ifdef ROUTER_PKT_GEN_PERR_INJ_EN
  logic              perr_inj;
`endif

  modport master (
    input  req_valid, req_addr, req_len,
    input  pay_valid, pay_data,
    input  busy,
`ifdef ROUTER_PKT_GEN_PERR_INJ_EN
    input  perr_inj,
`endif
    output req_ready, pay_ready, pkt_valid, data_out, pkt_cnt, drop_cnt
  );

  modport slave (
    output req_valid, req_addr, req_len,
    output pay_valid, pay_data,
    output busy,
`ifdef ROUTER_PKT_GEN_PERR_INJ_EN
    output perr_inj,
`endif
    input  req_ready, pay_ready, pkt_valid, data_out, pkt_cnt, drop_cnt
  );

endinterface

// File: rtl/router_pkt_buf.sv
// router_pkt_buf
// 64x8 simple dual-port payload RAM: synchronous write, registered read.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address (data appears on rdata_o one cycle later)
//   rdata_o : read data
module router_pkt_buf
  import router_pkg::*;
(
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [LEN_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [LEN_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [BUF_DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Write-first on collision: a one-byte packet writes slot 0 on the same
  // edge the prefetch reads it, and the header cycle needs that byte.
  always_ff @(posedge clk_i) begin
    if (we_i && (waddr_i == raddr_i)) begin
      rdata_o <= wdata_i;
    end else begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/router_pkt_gen.sv
// router_pkt_gen
// Store-and-forward packet source for the 1x3 router. Buffers a whole
// payload, then emits header / payload / parity on pkt_valid/data_out,
// holding on busy, followed by IPG idle cycles.
//   clock  : clock, rising edge
//   resetn : synchronous active-low reset
//   pkt_if : request + payload handshakes, router pins, status counters
// Parameter IPG (1..15): idle cycles after each parity byte.
// Optional: ROUTER_PKT_GEN_PERR_INJ_EN adds perr_inj; when sampled high with
// a request, that packet's parity byte is inverted.
//
// state   | meaning
// IDLE    | ready for a request; zero-length requests are counted and dropped
// FILL    | accepting payload bytes into the buffer, accumulating parity
// HEADER  | header byte on data_out, pkt_valid high
// PAYLOAD | buffered payload bytes on data_out, pkt_valid high
// PARITY  | parity byte on data_out, pkt_valid low
// GAP     | inter-packet gap, IPG cycles of all-zero output
module router_pkt_gen
  import router_pkg::*;
#(
  parameter int unsigned IPG = 2
) (
  input  logic             clock,
  input  logic             resetn,
  router_pkt_gen_if.master pkt_if
);

  localparam logic [3:0] GAP_LOAD = 4'(IPG - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [LEN_W-1:0]  rd_idx_q, rd_idx_d;
  logic [DATA_W-1:0] parity_q, parity_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              pkt_valid_q, pkt_valid_d;
  logic [15:0]       pkt_cnt_q, pkt_cnt_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;
  logic [3:0]        gap_q, gap_d;
  logic              perr_q, perr_d;

  logic              req_ready, pay_ready;
  logic              req_acc, pay_acc;
  logic              last_wr, last_rd;
  logic              buf_we;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] parity_byte;

  assign req_acc = pkt_if.req_valid & req_ready;
  assign pay_acc = pkt_if.pay_valid & pay_ready;
  assign last_wr = (wr_ptr_q == (len_q - 6'd1));
  // rd_idx_q indexes the byte waiting in rd_data; once it reaches len_q the
  // byte on data_out is the final payload byte.
  assign last_rd = (rd_idx_q == len_q);

`ifdef ROUTER_PKT_GEN_PERR_INJ_EN
  assign parity_byte = perr_q ? ~parity_q : parity_q;
`else
  assign parity_byte = parity_q;
`endif

  // Read address follows the next-state index so rd_data always holds the
  // next byte to send; this keeps back-to-back consumes bubble-free.
  router_pkt_buf u_buf (
    .clk_i   (clock),
    .we_i    (buf_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (pkt_if.pay_data),
    .raddr_i (rd_idx_d),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (req_acc && (pkt_if.req_len != '0)) state_d = ST_FILL;
      ST_FILL:    if (pay_acc && last_wr)                state_d = ST_HEADER;
      ST_HEADER:  if (!pkt_if.busy)                      state_d = ST_PAYLOAD;
      ST_PAYLOAD: if (!pkt_if.busy && last_rd)           state_d = ST_PARITY;
      ST_PARITY:  if (!pkt_if.busy)                      state_d = ST_GAP;
      ST_GAP:     if (gap_q == '0)                       state_d = ST_IDLE;
      default:                                           state_d = ST_IDLE;
    endcase
  end

  // Outputs: handshake readies straight from state, plus the next values of
  // the registered router pins.
  always_comb begin
    req_ready   = 1'b0;
    pay_ready   = 1'b0;
    data_out_d  = data_out_q;
    pkt_valid_d = pkt_valid_q;
    case (state_q)
      ST_IDLE: begin
        req_ready   = 1'b1;
        data_out_d  = '0;
        pkt_valid_d = 1'b0;
      end
      ST_FILL: begin
        pay_ready = 1'b1;
        if (pkt_if.pay_valid && last_wr) begin
          data_out_d  = hdr_byte(len_q, addr_q);
          pkt_valid_d = 1'b1;
        end
      end
      ST_HEADER: begin
        if (!pkt_if.busy) begin
          data_out_d  = rd_data;
          pkt_valid_d = 1'b1;
        end
      end
      ST_PAYLOAD: begin
        if (!pkt_if.busy) begin
          if (last_rd) begin
            data_out_d  = parity_byte;
            pkt_valid_d = 1'b0;
          end else begin
            data_out_d  = rd_data;
            pkt_valid_d = 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (!pkt_if.busy) begin
          data_out_d  = '0;
          pkt_valid_d = 1'b0;
        end
      end
      default: begin
        data_out_d  = '0;
        pkt_valid_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    addr_d     = addr_q;
    len_d      = len_q;
    wr_ptr_d   = wr_ptr_q;
    rd_idx_d   = rd_idx_q;
    parity_d   = parity_q;
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    gap_d      = gap_q;
    perr_d     = perr_q;
    buf_we     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_acc) begin
          if (pkt_if.req_len == '0) begin
            if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
          end else begin
            addr_d   = pkt_if.req_addr;
            len_d    = pkt_if.req_len;
            wr_ptr_d = '0;
            rd_idx_d = '0;
            parity_d = hdr_byte(pkt_if.req_len, pkt_if.req_addr);
`ifdef ROUTER_PKT_GEN_PERR_INJ_EN
            perr_d   = pkt_if.perr_inj;
`else
            perr_d   = 1'b0;
`endif
          end
        end
      end
      ST_FILL: begin
        if (pay_acc) begin
          buf_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 6'd1;
          parity_d = parity_q ^ pkt_if.pay_data;
        end
      end
      ST_HEADER: begin
        if (!pkt_if.busy) rd_idx_d = rd_idx_q + 6'd1;
      end
      ST_PAYLOAD: begin
        if (!pkt_if.busy && !last_rd) rd_idx_d = rd_idx_q + 6'd1;
      end
      ST_PARITY: begin
        if (!pkt_if.busy) begin
          pkt_cnt_d = pkt_cnt_q + 16'd1;
          gap_d     = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (gap_q != '0) gap_d = gap_q - 4'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      addr_q      <= '0;
      len_q       <= '0;
      wr_ptr_q    <= '0;
      rd_idx_q    <= '0;
      parity_q    <= '0;
      data_out_q  <= '0;
      pkt_valid_q <= 1'b0;
      pkt_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      gap_q       <= '0;
      perr_q      <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      len_q       <= len_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_idx_q    <= rd_idx_d;
      parity_q    <= parity_d;
      data_out_q  <= data_out_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_cnt_q   <= pkt_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      gap_q       <= gap_d;
      perr_q      <= perr_d;
    end
  end

  assign pkt_if.req_ready = req_ready;
  assign pkt_if.pay_ready = pay_ready;
  assign pkt_if.pkt_valid = pkt_valid_q;
  assign pkt_if.data_out  = data_out_q;
  assign pkt_if.pkt_cnt   = pkt_cnt_q;
  assign pkt_if.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_router_pkt_gen.sv
// tb_router_pkt_gen
// Self-checking bench for router_pkt_gen: a table of directed packets, a few
// hand-written multi-cycle sequences (mid-packet reset, drop saturation) and
// randomized packets checked against a byte-stream reference model.
module tb_router_pkt_gen;
  import router_pkg::*;

  localparam int IPG = 3;
`ifdef ROUTER_PKT_GEN_PERR_INJ_EN
  localparam bit PERR_EN = 1'b1;
`else
  localparam bit PERR_EN = 1'b0;
`endif

  typedef struct {
    logic [1:0] addr;
    logic [5:0] len;
    logic [7:0] start;
    logic [7:0] step;
    int         bmode;
    bit         perr;
    logic [7:0] exp_hdr;
    logic [7:0] exp_par;
  } vec_t;

  logic clock;
  logic resetn;

  router_pkt_gen_if bus ();

  router_pkt_gen #(.IPG(IPG)) dut (
    .clock  (clock),
    .resetn (resetn),
    .pkt_if (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total;
  int bad;
  int m_pkt;
  int m_drop;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sends one request (and its payload), then consumes and checks the
  // router-side stream against a model built from the packet rules.
  // bmode: 0 = never busy, 1 = busy for two header cycles and once mid-payload,
  // otherwise random busy.
  task automatic do_pkt(input logic [1:0] addr, input logic [5:0] len,
                        input logic [7:0] start, input logic [7:0] step,
                        input int bmode, input bit perr, input bit gappy,
                        output logic [7:0] got_hdr, output logic [7:0] got_par);
    logic [7:0] pl [$];
    logic [7:0] exp_b [$];
    logic       exp_v [$];
    logic [7:0] par;
    int         i, k, cyc, wd, gap;
    bit         b, acc, mid_done;

    got_hdr = 8'h00;
    got_par = 8'h00;
    wd = 0;
    while (bus.req_ready !== 1'b1 && wd < 100) begin
      @(negedge clock);
      wd++;
    end
    check("req_ready_idle", 32'(bus.req_ready), 32'd1);

    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_len   = len;
`ifdef ROUTER_PKT_GEN_PERR_INJ_EN
    bus.perr_inj  = perr;
`endif
    @(negedge clock);
    bus.req_valid = 1'b0;
`ifdef ROUTER_PKT_GEN_PERR_INJ_EN
    bus.perr_inj  = 1'b0;
`endif

    if (len == 6'd0) begin
      m_drop = (m_drop >= 255) ? 255 : m_drop + 1;
      check("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
      check("req_ready_after_drop", 32'(bus.req_ready), 32'd1);
      check("pkt_valid_after_drop", 32'(bus.pkt_valid), 32'd0);
      return;
    end
    check("pay_ready_t1", 32'(bus.pay_ready), 32'd1);

    for (int j = 0; j < int'(len); j++) pl.push_back(8'(start + step * 8'(j)));
    par = {len, addr};
    exp_b.push_back({len, addr});
    exp_v.push_back(1'b1);
    foreach (pl[j]) begin
      exp_b.push_back(pl[j]);
      exp_v.push_back(1'b1);
      par = par ^ pl[j];
    end
    exp_b.push_back(perr ? ~par : par);
    exp_v.push_back(1'b0);

    i = 0;
    wd = 0;
    while (i < int'(len) && wd < 1000) begin
      b = gappy ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.pay_valid = b;
      bus.pay_data  = b ? pl[i] : 8'($urandom);
      bus.req_valid = 1'($urandom_range(0, 1));
      bus.req_addr  = 2'($urandom);
      bus.req_len   = 6'($urandom);
      acc = b && (bus.pay_ready === 1'b1);
      @(negedge clock);
      if (acc) i++;
      wd++;
    end
    bus.pay_valid = 1'b0;
    bus.req_valid = 1'b0;
    check("fill_done", 32'(i), 32'(len));

    k = 0;
    cyc = 0;
    mid_done = 1'b0;
    while (k < exp_b.size() && cyc < 1000) begin
      if (bmode == 0) begin
        b = 1'b0;
      end else if (bmode == 1) begin
        b = (cyc < 2) || (k == 2 && !mid_done);
        if (k == 2 && b) mid_done = 1'b1;
      end else begin
        b = ($urandom_range(0, 3) == 0);
      end
      bus.busy      = b;
      bus.pay_valid = 1'($urandom_range(0, 1));
      bus.pay_data  = 8'($urandom);
      bus.req_valid = 1'($urandom_range(0, 1));
      check("out_byte", 32'(bus.data_out), 32'(exp_b[k]));
      check("out_valid", 32'(bus.pkt_valid), 32'(exp_v[k]));
      check("pay_ready_low", 32'(bus.pay_ready), 32'd0);
      if (k == 0) got_hdr = bus.data_out;
      if (k == exp_b.size() - 1) got_par = bus.data_out;
      @(negedge clock);
      if (!b) k++;
      cyc++;
    end
    bus.busy      = 1'b0;
    bus.pay_valid = 1'b0;
    bus.req_valid = 1'b0;
    check("out_done", 32'(k), 32'(exp_b.size()));
    if (bmode == 0) check("out_cycles", 32'(cyc), 32'(int'(len) + 2));

    m_pkt = (m_pkt + 1) & 32'hFFFF;
    check("pkt_cnt", 32'(bus.pkt_cnt), 32'(m_pkt));

    gap = 0;
    while (bus.req_ready !== 1'b1 && gap < 40) begin
      check("gap_quiet", {23'd0, bus.pkt_valid, bus.data_out}, 32'd0);
      gap++;
      @(negedge clock);
    end
    check("gap_len", 32'(gap), 32'(IPG));
  endtask

  initial begin
    vec_t       vecs [6];
    logic [7:0] gh, gp;
    logic [1:0] ra;
    logic [5:0] rl;

    total  = 0;
    bad    = 0;
    m_pkt  = 0;
    m_drop = 0;

    vecs[0] = '{2'd1, 6'd3,  8'hA1, 8'h11, 0, PERR_EN, 8'h0D, PERR_EN ? 8'h22 : 8'hDD};
    vecs[1] = '{2'd1, 6'd3,  8'hA1, 8'h11, 1, 1'b0,    8'h0D, 8'hDD};
    vecs[2] = '{2'd0, 6'd0,  8'h00, 8'h00, 0, 1'b0,    8'h00, 8'h00};
    vecs[3] = '{2'd2, 6'd63, 8'h00, 8'h01, 0, 1'b0,    8'hFE, 8'hC1};
    vecs[4] = '{2'd3, 6'd1,  8'h5A, 8'h00, 2, 1'b0,    8'h07, 8'h5D};
    vecs[5] = '{2'd0, 6'd2,  8'h80, 8'h01, 1, 1'b0,    8'h08, 8'h09};

    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.pay_valid = 1'b0;
    bus.pay_data  = '0;
    bus.busy      = 1'b0;
`ifdef ROUTER_PKT_GEN_PERR_INJ_EN
    bus.perr_inj  = 1'b0;
`endif
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_pkt_valid", 32'(bus.pkt_valid), 32'd0);
    check("rst_data_out", 32'(bus.data_out), 32'd0);
    check("rst_pkt_cnt", 32'(bus.pkt_cnt), 32'd0);
    check("rst_drop_cnt", 32'(bus.drop_cnt), 32'd0);
    check("rst_pay_ready", 32'(bus.pay_ready), 32'd0);
    resetn = 1'b1;
    @(negedge clock);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);

    for (int v = 0; v < 6; v++) begin
      do_pkt(vecs[v].addr, vecs[v].len, vecs[v].start, vecs[v].step,
             vecs[v].bmode, vecs[v].perr, 1'b0, gh, gp);
      if (vecs[v].len != 6'd0) begin
        check("tbl_hdr", 32'(gh), 32'(vecs[v].exp_hdr));
        check("tbl_par", 32'(gp), 32'(vecs[v].exp_par));
      end
    end

    // Reset in the middle of PAYLOAD, coinciding with busy low.
    bus.req_valid = 1'b1;
    bus.req_addr  = 2'd1;
    bus.req_len   = 6'd5;
    @(negedge clock);
    bus.req_valid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      bus.pay_valid = 1'b1;
      bus.pay_data  = 8'(8'h10 + j);
      @(negedge clock);
    end
    bus.pay_valid = 1'b0;
    check("abort_hdr", 32'(bus.data_out), 32'h15);
    @(negedge clock);
    check("abort_pay0", 32'(bus.data_out), 32'h10);
    resetn = 1'b0;
    @(negedge clock);
    check("abort_pkt_valid", 32'(bus.pkt_valid), 32'd0);
    check("abort_data_out", 32'(bus.data_out), 32'd0);
    check("abort_pkt_cnt", 32'(bus.pkt_cnt), 32'd0);
    check("abort_drop_cnt", 32'(bus.drop_cnt), 32'd0);
    check("abort_pay_ready", 32'(bus.pay_ready), 32'd0);
    resetn = 1'b1;
    @(negedge clock);
    check("abort_req_ready", 32'(bus.req_ready), 32'd1);
    check("abort_quiet", 32'(bus.pkt_valid), 32'd0);
    m_pkt  = 0;
    m_drop = 0;

    do_pkt(2'd1, 6'd4, 8'h33, 8'h07, 0, 1'b0, 1'b1, gh, gp);
    check("post_abort_hdr", 32'(gh), 32'h11);

    // Back-to-back zero-length requests push drop_cnt into saturation.
    bus.req_valid = 1'b1;
    bus.req_addr  = 2'd2;
    bus.req_len   = 6'd0;
    repeat (260) @(negedge clock);
    bus.req_valid = 1'b0;
    check("drop_sat", 32'(bus.drop_cnt), 32'd255);
    check("drop_sat_quiet", 32'(bus.pkt_valid), 32'd0);
    check("drop_sat_pkt_cnt", 32'(bus.pkt_cnt), 32'(m_pkt));
    m_drop = 255;
    do_pkt(2'd0, 6'd0, 8'h00, 8'h00, 0, 1'b0, 1'b0, gh, gp);

    for (int r = 0; r < 30; r++) begin
      ra = 2'($urandom);
      rl = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 8));
      do_pkt(ra, rl, 8'($urandom), 8'($urandom), 2,
             PERR_EN && ($urandom_range(0, 1) == 1), 1'b1, gh, gp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
